// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: derives empty from the synchronized
// write pointer, issues memory reads, and re-times read data through a 2-entry skid buffer.
module fifo_rd_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int NUM_BITS  = 4,
  parameter int DEPTH     = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic [NUM_BITS:0]    w_ptr_gray_sync,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  input  logic                 out_ready,
  output logic                 rd_en,
  output logic [NUM_BITS-1:0]  rd_addr,
  output logic [NUM_BITS:0]    rd_ptr_gray,
  output logic                 empty,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid
);

  if (DEPTH != (1 << NUM_BITS)) begin : g_depth_check
    $error("fifo_rd_ctrl: DEPTH must equal 2**NUM_BITS");
  end

  logic [NUM_BITS:0]    rdPtrBin_q, rdPtrBin_d;
  logic [NUM_BITS:0]    rdPtrGray_q, rdPtrGray_d;
  logic                 empty_q, empty_d;
  logic                 inflight_q;
  logic [1:0]           occ_q, occ_d;
  logic [DATA_BITS-1:0] buf0_q, buf0_d;
  logic [DATA_BITS-1:0] buf1_q, buf1_d;
  logic                 pop;
  logic [1:0]           credit;

  // A read is only issued when the buffer is guaranteed a free slot for it next cycle.
  always_comb begin
    pop         = (occ_q != 2'd0) & out_ready;
    credit      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_en       = !empty_q && (credit <= 2'd1);
    rdPtrBin_d  = rdPtrBin_q + {{NUM_BITS{1'b0}}, rd_en};
    rdPtrGray_d = rdPtrBin_d ^ (rdPtrBin_d >> 1);
    empty_d     = (rdPtrGray_d == w_ptr_gray_sync);
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = mem_rd_data;
        else               buf1_d = mem_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = mem_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rdPtrBin_q  <= '0;
      rdPtrGray_q <= '0;
      empty_q     <= 1'b1;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      rdPtrBin_q  <= rdPtrBin_d;
      rdPtrGray_q <= rdPtrGray_d;
      empty_q     <= empty_d;
      inflight_q  <= rd_en;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign rd_addr     = rdPtrBin_q[NUM_BITS-1:0];
  assign rd_ptr_gray = rdPtrGray_q;
  assign empty       = empty_q;
  assign out_data    = buf0_q;
  assign out_valid   = (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a write-side/memory model feeds a queue of expected words, and a
// per-cycle monitor compares the DUT against flags and pointers derived from word counts.
module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b1;
  logic [4:0] w_ptr_gray_sync = '0;
  logic [7:0] mem_rd_data;
  logic       out_ready = 1'b0;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic [7:0] out_data;
  logic       out_valid;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [7:0] mem [16];
  logic [4:0] wBin = '0;
  logic [7:0] expQ [$];

  // Model state for the monitor: words issued/popped since reset and last-cycle history.
  bit         monOn = 1'b0;
  int         issued = 0;
  int         popped = 0;
  logic       prevRdEn = 1'b0;
  logic [4:0] prevW = '0;
  logic       prevHeld = 1'b0;
  logic [7:0] prevData = '0;

  fifo_rd_ctrl #(.DATA_BITS(8), .NUM_BITS(4), .DEPTH(16)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .w_ptr_gray_sync(w_ptr_gray_sync),
    .mem_rd_data(mem_rd_data), .out_ready(out_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_ptr_gray(rd_ptr_gray), .empty(empty),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 rd_clk = ~rd_clk;

  // Registered-output dual-port memory: data appears the cycle after the read strobe.
  always @(posedge rd_clk) if (rd_en) mem_rd_data <= mem[rd_addr];

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic pushWord(input logic [7:0] d);
    mem[wBin[3:0]] = d;
    expQ.push_back(d);
    wBin = wBin + 5'd1;
    w_ptr_gray_sync = toGray(wBin);
  endtask

  task automatic resetDut(input int cycles);
    monOn = 1'b0;
    rd_rst = 1'b1;
    wBin = '0;
    w_ptr_gray_sync = '0;
    expQ.delete();
    repeat (cycles) tick();
    rd_rst = 1'b0;
    issued = 0; popped = 0; prevRdEn = 1'b0; prevW = '0; prevHeld = 1'b0;
    monOn = 1'b1;
  endtask

  // Per-cycle monitor at the falling edge, checking against count-based expectations.
  always @(negedge rd_clk) begin
    if (monOn) begin
      int outstanding;
      logic expEmpty, expValid, expRdEn, popNow;
      outstanding = issued - popped;
      expEmpty = (toGray(5'(issued)) == prevW);
      expValid = (outstanding - int'(prevRdEn)) > 0;
      expRdEn  = !expEmpty && ((outstanding - int'(expValid && out_ready)) <= 1);
      totalChecks += 6;
      if (empty !== expEmpty) begin badChecks++; $display("[TB] FAIL mon_empty got=%b exp=%b t=%0t", empty, expEmpty, $time); end
      if (out_valid !== expValid) begin badChecks++; $display("[TB] FAIL mon_valid got=%b exp=%b t=%0t", out_valid, expValid, $time); end
      if (rd_en !== expRdEn) begin badChecks++; $display("[TB] FAIL mon_rd_en got=%b exp=%b t=%0t", rd_en, expRdEn, $time); end
      if (rd_addr !== 4'(issued)) begin badChecks++; $display("[TB] FAIL mon_addr got=%0d exp=%0d t=%0t", rd_addr, 4'(issued), $time); end
      if (rd_ptr_gray !== toGray(5'(issued))) begin badChecks++; $display("[TB] FAIL mon_gray got=%h exp=%h t=%0t", rd_ptr_gray, toGray(5'(issued)), $time); end
      if (outstanding > 2) begin badChecks++; $display("[TB] FAIL mon_credit got=%0d exp<=2 t=%0t", outstanding, $time); end
      if (prevHeld) begin
        totalChecks++;
        if (out_valid !== 1'b1 || out_data !== prevData) begin
          badChecks++;
          $display("[TB] FAIL mon_stable got=%b/%h exp=1/%h t=%0t", out_valid, out_data, prevData, $time);
        end
      end
      popNow = out_valid && out_ready;
      if (popNow) begin
        totalChecks++;
        if (expQ.size() == 0) begin
          badChecks++;
          $display("[TB] FAIL mon_data got=%h exp=none t=%0t", out_data, $time);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          if (out_data !== e) begin badChecks++; $display("[TB] FAIL mon_data got=%h exp=%h t=%0t", out_data, e, $time); end
        end
      end
      if (rd_en === 1'b1) issued++;
      if (popNow) popped++;
      prevRdEn = rd_en;
      prevW    = w_ptr_gray_sync;
      prevHeld = out_valid && !out_ready;
      prevData = out_data;
    end
  end

  task automatic test_reset();
    resetDut(2);
    #1;
    totalChecks += 5;
    if (empty !== 1'b1) begin badChecks++; $display("[TB] FAIL rst_empty got=%b exp=1", empty); end
    if (rd_en !== 1'b0) begin badChecks++; $display("[TB] FAIL rst_rd_en got=%b exp=0", rd_en); end
    if (out_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL rst_valid got=%b exp=0", out_valid); end
    if (rd_addr !== 4'd0) begin badChecks++; $display("[TB] FAIL rst_addr got=%0d exp=0", rd_addr); end
    if (rd_ptr_gray !== 5'd0) begin badChecks++; $display("[TB] FAIL rst_gray got=%h exp=0", rd_ptr_gray); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    pushWord(8'hA5);
    tick(); #1;
    totalChecks += 3;
    if (empty !== 1'b0) begin badChecks++; $display("[TB] FAIL sw_empty_fall got=%b exp=0", empty); end
    if (rd_en !== 1'b1) begin badChecks++; $display("[TB] FAIL sw_rd_en got=%b exp=1", rd_en); end
    if (rd_addr !== 4'd0) begin badChecks++; $display("[TB] FAIL sw_addr got=%0d exp=0", rd_addr); end
    tick(); #1;
    totalChecks += 2;
    if (rd_en !== 1'b0) begin badChecks++; $display("[TB] FAIL sw_single_pulse got=%b exp=0", rd_en); end
    if (out_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL sw_early_valid got=%b exp=0", out_valid); end
    tick(); #1;
    totalChecks += 4;
    if (out_valid !== 1'b1) begin badChecks++; $display("[TB] FAIL sw_valid got=%b exp=1", out_valid); end
    if (out_data !== 8'hA5) begin badChecks++; $display("[TB] FAIL sw_data got=%h exp=a5", out_data); end
    if (rd_ptr_gray !== 5'd1) begin badChecks++; $display("[TB] FAIL sw_gray got=%h exp=1", rd_ptr_gray); end
    if (empty !== 1'b1) begin badChecks++; $display("[TB] FAIL sw_empty_rise got=%b exp=1", empty); end
    tick(); #1;
    totalChecks++;
    if (out_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL sw_valid_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    int enCount = 0, firstEn = -1, lastEn = -1;
    int popCount = 0, firstPop = -1, lastPop = -1;
    resetDut(2);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) pushWord(8'(i));
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick(); #1;
      if (rd_en) begin
        if (firstEn < 0) firstEn = cyc;
        lastEn = cyc;
        enCount++;
      end
      if (out_valid) begin
        totalChecks++;
        if (out_data !== 8'(popCount)) begin badChecks++; $display("[TB] FAIL st_data got=%h exp=%h", out_data, 8'(popCount)); end
        if (firstPop < 0) firstPop = cyc;
        lastPop = cyc;
        popCount++;
      end
    end
    totalChecks += 7;
    if (enCount !== 16) begin badChecks++; $display("[TB] FAIL st_en_count got=%0d exp=16", enCount); end
    if (lastEn - firstEn !== 15) begin badChecks++; $display("[TB] FAIL st_en_span got=%0d exp=15", lastEn - firstEn); end
    if (popCount !== 16) begin badChecks++; $display("[TB] FAIL st_pop_count got=%0d exp=16", popCount); end
    if (lastPop - firstPop !== 15) begin badChecks++; $display("[TB] FAIL st_pop_span got=%0d exp=15", lastPop - firstPop); end
    if (firstPop - firstEn !== 2) begin badChecks++; $display("[TB] FAIL st_latency got=%0d exp=2", firstPop - firstEn); end
    if (rd_ptr_gray !== 5'h18) begin badChecks++; $display("[TB] FAIL st_gray got=%h exp=18", rd_ptr_gray); end
    if (rd_addr !== 4'd0) begin badChecks++; $display("[TB] FAIL st_addr got=%0d exp=0", rd_addr); end
  endtask

  task automatic test_backpressure();
    int enCount = 0, k = 0, gaps = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pushWord(8'h50 + 8'(i));
    #1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick(); #1;
      if (rd_en) enCount++;
      if (out_valid) begin
        totalChecks++;
        if (out_data !== 8'h50) begin badChecks++; $display("[TB] FAIL bp_hold got=%h exp=50", out_data); end
      end
    end
    totalChecks += 2;
    if (enCount !== 2) begin badChecks++; $display("[TB] FAIL bp_issue got=%0d exp=2", enCount); end
    if (out_valid !== 1'b1) begin badChecks++; $display("[TB] FAIL bp_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        totalChecks++;
        if (out_data !== 8'h50 + 8'(k)) begin badChecks++; $display("[TB] FAIL bp_order got=%h exp=%h", out_data, 8'h50 + 8'(k)); end
        k++;
      end else if (k > 0 && k < 5) begin
        gaps++;
      end
      tick(); #1;
    end
    totalChecks += 2;
    if (k !== 5) begin badChecks++; $display("[TB] FAIL bp_count got=%0d exp=5", k); end
    if (gaps !== 0) begin badChecks++; $display("[TB] FAIL bp_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_wrap_random();
    logic [7:0] expWords [40];
    int written = 0, got = 0, iss = 0, cyc = 0;
    bit chk16 = 0, chk32 = 0;
    resetDut(2);
    while (got < 40 && cyc < 3000) begin
      tick();
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (written < 40 && (written - got) < 16 && $urandom_range(0, 1) == 1) begin
        expWords[written] = 8'($urandom);
        pushWord(expWords[written]);
        written++;
      end
      #1;
      if (iss == 16 && !chk16) begin
        chk16 = 1;
        totalChecks++;
        if (rd_ptr_gray[4] !== 1'b1) begin badChecks++; $display("[TB] FAIL wr_msb16 got=%b exp=1", rd_ptr_gray[4]); end
      end
      if (iss == 32 && !chk32) begin
        chk32 = 1;
        totalChecks++;
        if (rd_ptr_gray[4] !== 1'b0) begin badChecks++; $display("[TB] FAIL wr_msb32 got=%b exp=0", rd_ptr_gray[4]); end
      end
      if (out_valid && out_ready) begin
        totalChecks++;
        if (out_data !== expWords[got]) begin badChecks++; $display("[TB] FAIL wr_data idx=%0d got=%h exp=%h", got, out_data, expWords[got]); end
        got++;
      end
      if (rd_en) iss++;
    end
    totalChecks += 2;
    if (got !== 40) begin badChecks++; $display("[TB] FAIL wr_count got=%0d exp=40", got); end
    if ((chk16 && chk32) !== 1'b1) begin badChecks++; $display("[TB] FAIL wr_msb_seen got=%b%b exp=11", chk16, chk32); end
  endtask

  task automatic test_mid_reset();
    bit seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) pushWord(8'hC0 + 8'(i));
    repeat (4) tick();
    #1;
    totalChecks++;
    if (out_valid !== 1'b1) begin badChecks++; $display("[TB] FAIL mr_prefill got=%b exp=1", out_valid); end
    resetDut(1);
    #1;
    totalChecks += 5;
    if (out_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL mr_valid got=%b exp=0", out_valid); end
    if (empty !== 1'b1) begin badChecks++; $display("[TB] FAIL mr_empty got=%b exp=1", empty); end
    if (rd_addr !== 4'd0) begin badChecks++; $display("[TB] FAIL mr_addr got=%0d exp=0", rd_addr); end
    if (rd_ptr_gray !== 5'd0) begin badChecks++; $display("[TB] FAIL mr_gray got=%h exp=0", rd_ptr_gray); end
    if (rd_en !== 1'b0) begin badChecks++; $display("[TB] FAIL mr_rd_en got=%b exp=0", rd_en); end
    out_ready = 1'b1;
    pushWord(8'h3C);
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      tick(); #1;
      if (out_valid) begin
        seen = 1;
        totalChecks++;
        if (out_data !== 8'h3C) begin badChecks++; $display("[TB] FAIL mr_fresh got=%h exp=3c", out_data); end
      end
    end
    totalChecks++;
    if (seen !== 1'b1) begin badChecks++; $display("[TB] FAIL mr_timeout got=%b exp=1", seen); end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_wrap_random();
    test_mid_reset();
    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
